sram_mem_controller: RTL and testbench

//  MEM-stage bridge between the core's 32-bit load/store requests and an off-chip
//  16-bit asynchronous SRAM. Splits each word access into two halfword phases (low, high),

---
 rtl/sram_mem_controller_pkg.sv | 15 +
 rtl/sram_mem_controller_if.sv | 49 ++++
 rtl/sram_mem_controller.sv | 120 ++++++++++++
 tb/tb_sram_mem_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM bridge.
// Imported by the interface and the controller.
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_e;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int          SRAM_DW       = 16;

endpackage

// File: rtl/sram_mem_controller_if.sv
// Core-side load/store request and SRAM pin bundle.
// The controller takes the slave side.
interface sram_mem_controller_if
    import sram_mem_controller_pkg::*;
#(
    parameter int SRAM_AW = 18
);

    logic                wr_en;
    logic                rd_en;
    logic [31:0]         address;
    logic [31:0]         write_data;
    logic [31:0]         read_data;
    logic                ready;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [SRAM_DW-1:0]  sram_dq_out;
    logic                sram_dq_oe;
    logic [SRAM_DW-1:0]  sram_dq_in;
    logic                sram_we_n;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output write_data,
        output sram_dq_in,
        input  read_data,
        input  ready,
        input  sram_addr,
        input  sram_dq_out,
        input  sram_dq_oe,
        input  sram_we_n
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  write_data,
        input  sram_dq_in,
        output read_data,
        output ready,
        output sram_addr,
        output sram_dq_out,
        output sram_dq_oe,
        output sram_we_n
    );

endinterface

// File: rtl/sram_mem_controller.sv
// MEM-stage bridge: one 32-bit load/store becomes two 16-bit SRAM
// phases (low, high); ready holds the pipeline until the access is done.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_mem_controller_if.slave bus
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam int WW = SRAM_AW - 1;

    state_e             state_q;
    state_e             state_d;
    logic [CW-1:0]      cnt_q;
    logic               op_wr_q;
    logic [WW-1:0]      word_q;
    logic [31:0]        wdata_q;
    logic [SRAM_DW-1:0] lo_q;
    logic [31:0]        rdata_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [SRAM_DW-1:0] dq_q;
    logic               oe_q;
    logic               we_n_q;

    logic               req;
    logic               last;
    logic [31:0]        offset;
    logic [WW-1:0]      word_d;
    logic               unused_ok;

    assign req       = bus.wr_en | bus.rd_en;
    assign last      = (cnt_q == LAST);
    assign offset    = bus.address - 32'(BASE_ADDR);
    assign word_d    = offset[WW+1:2];
    assign unused_ok = ^{offset[31:WW+2], offset[1:0]};

    assign bus.ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
    assign bus.read_data   = rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req)  state_d = LO;
            LO:   if (last) state_d = HI;
            HI:   if (last) state_d = DONE;
            DONE:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Pin registers are loaded on the transition into each phase so the
    // SRAM sees stable, glitch-free levels for the whole phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        op_wr_q <= bus.wr_en;
                        word_q  <= word_d;
                        wdata_q <= bus.write_data;
                        cnt_q   <= '0;
                        addr_q  <= {word_d, 1'b0};
                        dq_q    <= bus.write_data[15:0];
                        oe_q    <= bus.wr_en;
                        we_n_q  <= ~bus.wr_en;
                    end
                end
                LO: begin
                    if (last) begin
                        cnt_q  <= '0;
                        lo_q   <= bus.sram_dq_in;
                        addr_q <= {word_q, 1'b1};
                        dq_q   <= wdata_q[31:16];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt_q  <= '0;
                        oe_q   <= 1'b0;
                        we_n_q <= 1'b1;
                        // Whole word lands at once; no half-updated load result.
                        if (!op_wr_q) rdata_q <= {bus.sram_dq_in, lo_q};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: cnt_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for the SRAM bridge: store/load, back-to-back,
// simultaneous requests, async reset and a WAIT_CYCLES=1 wrap instance.
module tb_sram_mem_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sram_mem_controller_if #(.SRAM_AW(18)) bus ();
    sram_mem_controller_if #(.SRAM_AW(18)) bus1 ();

    sram_mem_controller #(.SRAM_AW(18), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sram_mem_controller #(.SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [15:0] mem [16] = '{default: 16'h0};

    always @(posedge clk)
        if (!bus.sram_we_n) mem[bus.sram_addr[3:0]] <= bus.sram_dq_out;

    assign bus.sram_dq_in  = mem[bus.sram_addr[3:0]];
    assign bus1.sram_dq_in = 16'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic access(input bit wr, input bit rd,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [16:0] ew, input logic [31:0] exp_rd,
                          input bit perturb, input string tag);
        bit hi;
        @(negedge clk);
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = a;
        bus.write_data = wd;
        #1 chk({tag, "_c0_rdy"}, 32'(bus.ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                hi = (k > 2);
                chk($sformatf("%s_c%0d_addr", tag, k), 32'(bus.sram_addr),
                    32'({ew, hi}));
                chk($sformatf("%s_c%0d_wen", tag, k), 32'(bus.sram_we_n),
                    32'(!wr));
                chk($sformatf("%s_c%0d_oe", tag, k), 32'(bus.sram_dq_oe),
                    32'(wr));
                if (wr)
                    chk($sformatf("%s_c%0d_dq", tag, k), 32'(bus.sram_dq_out),
                        hi ? 32'(wd[31:16]) : 32'(wd[15:0]));
                chk($sformatf("%s_c%0d_rdy", tag, k), 32'(bus.ready), 32'd0);
                if (perturb && k == 3) begin
                    bus.address    = 32'd1044;
                    bus.write_data = ~wd;
                end
            end else begin
                chk({tag, "_done_rdy"}, 32'(bus.ready), 32'd1);
                chk({tag, "_done_wen"}, 32'(bus.sram_we_n), 32'd1);
                chk({tag, "_done_oe"}, 32'(bus.sram_dq_oe), 32'd0);
                chk({tag, "_done_rd"}, bus.read_data, exp_rd);
            end
        end
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #1 chk({tag, "_idle_rdy"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.address     = 32'h0;
        bus.write_data  = 32'h0;
        bus1.wr_en      = 1'b0;
        bus1.rd_en      = 1'b0;
        bus1.address    = 32'h0;
        bus1.write_data = 32'h0;

        #12;
        chk("rst_wen", 32'(bus.sram_we_n), 32'd1);
        chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_dq", 32'(bus.sram_dq_out), 32'd0);
        chk("rst_rd", bus.read_data, 32'd0);
        chk("rst_rdy", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 17'd0, 32'h0, 1'b0, "st0");
        idle("st0");
        access(1'b0, 1'b1, 32'd1024, 32'h0, 17'd0, 32'hDEADBEEF, 1'b0, "ld0");
        idle("ld0");
        chk("ld0_hold", bus.read_data, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 17'd1, 32'hDEADBEEF, 1'b0, "st1");
        access(1'b0, 1'b1, 32'd1028, 32'h0, 17'd1, 32'hCAFEF00D, 1'b0, "ld1");
        idle("ld1");

        access(1'b1, 1'b1, 32'd1032, 32'h12345678, 17'd2, 32'hCAFEF00D, 1'b1, "both");
        idle("both");
        access(1'b0, 1'b1, 32'd1032, 32'h0, 17'd2, 32'h12345678, 1'b0, "ld2");
        idle("ld2");

        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.address    = 32'd1040;
        bus.write_data = 32'h11112222;
        @(negedge clk);
        chk("ab_lo_wen", 32'(bus.sram_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_wen", 32'(bus.sram_we_n), 32'd1);
        chk("ab_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("ab_rd", bus.read_data, 32'd0);
        chk("ab_addr", 32'(bus.sram_addr), 32'd0);
        chk("ab_dq", 32'(bus.sram_dq_out), 32'd0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        #1 chk("ab_idle_rdy", 32'(bus.ready), 32'd1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 17'd1, 32'hCAFEF00D, 1'b0, "ld3");
        idle("ld3");

        @(negedge clk);
        bus1.wr_en      = 1'b1;
        bus1.address    = 32'h0008_0400;
        bus1.write_data = 32'hA5A55A5A;
        #1 chk("w1_c0_rdy", 32'(bus1.ready), 32'd0);
        @(negedge clk);
        chk("w1_c1_addr", 32'(bus1.sram_addr), 32'd0);
        chk("w1_c1_wen", 32'(bus1.sram_we_n), 32'd0);
        chk("w1_c1_dq", 32'(bus1.sram_dq_out), 32'h5A5A);
        chk("w1_c1_rdy", 32'(bus1.ready), 32'd0);
        @(negedge clk);
        chk("w1_c2_addr", 32'(bus1.sram_addr), 32'd1);
        chk("w1_c2_dq", 32'(bus1.sram_dq_out), 32'hA5A5);
        chk("w1_c2_rdy", 32'(bus1.ready), 32'd0);
        @(negedge clk);
        chk("w1_c3_rdy", 32'(bus1.ready), 32'd1);
        chk("w1_c3_wen", 32'(bus1.sram_we_n), 32'd1);
        bus1.wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
